// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO with arbitrary depth, occupancy count,
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and
// synchronous flush.
// Build option: define FIFO_SYNC_FWFT_EN for first-word-fall-through reads;
// otherwise rdata is registered with one cycle of latency and holds its value.
module fifo_sync_flags #(
  parameter int MEMORY_WIDTH  = 8,
  parameter int MEMORY_DEPTH  = 16,
  parameter int ADDRESS_SIZE  = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    clr_err,
  input  logic                    w_en,
  input  logic [MEMORY_WIDTH-1:0] wdata,
  input  logic                    r_en,
  output logic [MEMORY_WIDTH-1:0] rdata,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [ADDRESS_SIZE:0]   count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam logic [ADDRESS_SIZE:0]   L_DEPTH  = (ADDRESS_SIZE+1)'(MEMORY_DEPTH);
  localparam logic [ADDRESS_SIZE:0]   L_AFULL  = (ADDRESS_SIZE+1)'(AFULL_THRESH);
  localparam logic [ADDRESS_SIZE:0]   L_AEMPTY = (ADDRESS_SIZE+1)'(AEMPTY_THRESH);
  localparam logic [ADDRESS_SIZE-1:0] L_LAST   = ADDRESS_SIZE'(MEMORY_DEPTH - 1);

  logic [MEMORY_WIDTH-1:0] r_mem [0:MEMORY_DEPTH-1];
  logic [ADDRESS_SIZE-1:0] r_wptr;
  logic [ADDRESS_SIZE-1:0] r_rptr;
  logic [ADDRESS_SIZE:0]   r_count;
  logic                    r_overflow;
  logic                    r_underflow;

  logic w_full;
  logic w_empty;
  logic w_rd_ok;
  logic w_wr_ok;
  logic w_ovf_set;
  logic w_udf_set;

  // Pointers wrap at the last real entry, not at the power-of-two boundary.
  function automatic logic [ADDRESS_SIZE-1:0] f_next(input logic [ADDRESS_SIZE-1:0] p);
    if (p == L_LAST) return '0;
    return p + ADDRESS_SIZE'(1);
  endfunction

  // Status decode and accept logic; flush suppresses both accepts and errors.
  always_comb begin
    w_full    = (r_count == L_DEPTH);
    w_empty   = (r_count == '0);
    w_rd_ok   = r_en && !w_empty && !flush;
    w_wr_ok   = w_en && (!w_full || w_rd_ok) && !flush;
    w_ovf_set = w_en && !w_wr_ok && !flush;
    w_udf_set = r_en && !w_rd_ok && !flush;
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wptr] <= wdata;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_ok) r_wptr <= f_next(r_wptr);
      if (w_rd_ok) r_rptr <= f_next(r_rptr);
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a new error wins over clr_err in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set)    r_overflow <= 1'b1;
      else if (clr_err) r_overflow <= 1'b0;
      if (w_udf_set)    r_underflow <= 1'b1;
      else if (clr_err) r_underflow <= 1'b0;
    end
  end

`ifdef FIFO_SYNC_FWFT_EN
  // Head of queue is always visible; meaningless while empty.
  assign rdata = r_mem[r_rptr];
`else
  logic [MEMORY_WIDTH-1:0] r_rdata;

  // Registered read; old entry is captured even when a write hits the same slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_rdata <= '0;
    else if (w_rd_ok) r_rdata <= r_mem[r_rptr];
  end

  assign rdata = r_rdata;
`endif

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= L_AFULL);
  assign almost_empty = (r_count <= L_AEMPTY);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench for fifo_sync_flags: a 16-deep instance for flag, error,
// flush and reset behaviour, and a 5-deep instance for pointer wrap.
module tb_fifo_sync_flags;

  logic       clk;
  logic       rst;
  logic       flush, clr_err, w_en, r_en;
  logic [7:0] wdata, rdata;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       b_flush, b_clr_err, b_w_en, b_r_en;
  logic [7:0] b_wdata, b_rdata;
  logic       b_full, b_empty, b_almost_full, b_almost_empty, b_overflow, b_underflow;
  logic [3:0] b_count;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  fifo_sync_flags #(
    .MEMORY_WIDTH(8), .MEMORY_DEPTH(16), .ADDRESS_SIZE(4),
    .AFULL_THRESH(12), .AEMPTY_THRESH(2)
  ) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err),
    .w_en(w_en), .wdata(wdata), .r_en(r_en), .rdata(rdata),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  fifo_sync_flags #(
    .MEMORY_WIDTH(8), .MEMORY_DEPTH(5), .ADDRESS_SIZE(3),
    .AFULL_THRESH(4), .AEMPTY_THRESH(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .flush(b_flush), .clr_err(b_clr_err),
    .w_en(b_w_en), .wdata(b_wdata), .r_en(b_r_en), .rdata(b_rdata),
    .full(b_full), .empty(b_empty), .almost_full(b_almost_full),
    .almost_empty(b_almost_empty), .count(b_count),
    .overflow(b_overflow), .underflow(b_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"},  32'(count), 0);
    check({tag, "_empty"},  32'(empty), 1);
    check({tag, "_aempty"}, 32'(almost_empty), 1);
    check({tag, "_full"},   32'(full), 0);
    check({tag, "_afull"},  32'(almost_full), 0);
    check({tag, "_ovf"},    32'(overflow), 0);
    check({tag, "_udf"},    32'(underflow), 0);
`ifndef FIFO_SYNC_FWFT_EN
    check({tag, "_rdata"},  32'(rdata), 0);
`endif
  endtask

  initial begin
    int rd;
    logic [7:0] exp_b;
    rst = 1'b0; flush = 0; clr_err = 0; w_en = 0; r_en = 0; wdata = '0;
    b_flush = 0; b_clr_err = 0; b_w_en = 0; b_r_en = 0; b_wdata = '0;
    #2;
    check_reset_state("reset");
    tick();
    tick();
    rst = 1'b1;

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      w_en = 1; wdata = i[7:0];
      tick();
      check("fill_count",  32'(count), 32'(i + 1));
      check("fill_afull",  32'(almost_full), (i + 1 >= 12) ? 1 : 0);
      check("fill_full",   32'(full), (i == 15) ? 1 : 0);
      check("fill_aempty", 32'(almost_empty), (i + 1 <= 2) ? 1 : 0);
    end
    check("fill_ovf", 32'(overflow), 0);

    // Write while full: overflow, contents intact
    wdata = 8'hEE;
    tick();
    w_en = 0;
    check("ovf_set",   32'(overflow), 1);
    check("ovf_count", 32'(count), 16);
    clr_err = 1;
    tick();
    clr_err = 0;
    check("ovf_clr", 32'(overflow), 0);

    // Read+write at full
    w_en = 1; r_en = 1; wdata = 8'hAA;
`ifdef FIFO_SYNC_FWFT_EN
    check("rw_full_rdata", 32'(rdata), 32'h00);
`endif
    tick();
    w_en = 0; r_en = 0;
`ifndef FIFO_SYNC_FWFT_EN
    check("rw_full_rdata", 32'(rdata), 32'h00);
`endif
    check("rw_full_count", 32'(count), 16);
    check("rw_full_ovf",   32'(overflow), 0);

    // Drain: 0x01..0x0F then 0xAA
    for (int i = 0; i < 16; i++) begin
      r_en = 1;
`ifdef FIFO_SYNC_FWFT_EN
      check("drain_rdata", 32'(rdata), (i < 15) ? 32'(i + 1) : 32'hAA);
`endif
      tick();
`ifndef FIFO_SYNC_FWFT_EN
      check("drain_rdata", 32'(rdata), (i < 15) ? 32'(i + 1) : 32'hAA);
`endif
    end
    r_en = 0;
    check("drain_count", 32'(count), 0);
    check("drain_empty", 32'(empty), 1);
    check("drain_udf",   32'(underflow), 0);

    // Read while empty: underflow, rdata held
    r_en = 1;
    tick();
    r_en = 0;
    check("udf_set",   32'(underflow), 1);
    check("udf_count", 32'(count), 0);
`ifndef FIFO_SYNC_FWFT_EN
    check("udf_rdata", 32'(rdata), 32'hAA);
`endif
    clr_err = 1;
    tick();
    clr_err = 0;
    check("udf_clr", 32'(underflow), 0);

    // Single word 0x55
    w_en = 1; wdata = 8'h55;
    tick();
    w_en = 0;
    check("w55_empty", 32'(empty), 0);
    check("w55_count", 32'(count), 1);
`ifdef FIFO_SYNC_FWFT_EN
    check("w55_rdata", 32'(rdata), 32'h55);
`endif
    r_en = 1;
    tick();
    r_en = 0;
`ifndef FIFO_SYNC_FWFT_EN
    check("w55_rdata", 32'(rdata), 32'h55);
`endif
    check("r55_empty", 32'(empty), 1);

    // Read+write at empty: write accepted, read rejected
    w_en = 1; r_en = 1; wdata = 8'h66;
    tick();
    w_en = 0; r_en = 0;
    check("rw_empty_count", 32'(count), 1);
    check("rw_empty_udf",   32'(underflow), 1);
    clr_err = 1;
    tick();
    clr_err = 0;
    r_en = 1;
`ifdef FIFO_SYNC_FWFT_EN
    check("rw_empty_rdata", 32'(rdata), 32'h66);
`endif
    tick();
    r_en = 0;
`ifndef FIFO_SYNC_FWFT_EN
    check("rw_empty_rdata", 32'(rdata), 32'h66);
`endif
    check("rw_empty_udf_clr", 32'(underflow), 0);

    // Flush at 7 entries
    for (int i = 0; i < 7; i++) begin
      w_en = 1; wdata = 8'h30 + i[7:0];
      tick();
    end
    w_en = 0;
    check("pre_flush_count", 32'(count), 7);
    flush = 1; w_en = 1; r_en = 1; wdata = 8'hEE;
    tick();
    flush = 0; w_en = 0; r_en = 0;
    check("flush_count", 32'(count), 0);
    check("flush_empty", 32'(empty), 1);
    check("flush_ovf",   32'(overflow), 0);
    check("flush_udf",   32'(underflow), 0);
`ifndef FIFO_SYNC_FWFT_EN
    check("flush_rdata", 32'(rdata), 32'h66);
`endif
    w_en = 1; wdata = 8'h77;
    tick();
    w_en = 0;
    r_en = 1;
`ifdef FIFO_SYNC_FWFT_EN
    check("post_flush_rdata", 32'(rdata), 32'h77);
`endif
    tick();
    r_en = 0;
`ifndef FIFO_SYNC_FWFT_EN
    check("post_flush_rdata", 32'(rdata), 32'h77);
`endif

    // Async reset mid-burst with an error flag pending
    r_en = 1;
    tick();
    r_en = 0;
    check("pre_rst_udf", 32'(underflow), 1);
    w_en = 1; wdata = 8'h90;
    tick();
    wdata = 8'h91;
    tick();
    check("pre_rst_count", 32'(count), 2);
    #3;
    rst = 1'b0;
    #1;
    check_reset_state("midrst");
    rst = 1'b1;
    wdata = 8'h99;
    tick();
    w_en = 0;
    check("post_rst_count", 32'(count), 1);
    r_en = 1;
`ifdef FIFO_SYNC_FWFT_EN
    check("post_rst_rdata", 32'(rdata), 32'h99);
`endif
    tick();
    r_en = 0;
`ifndef FIFO_SYNC_FWFT_EN
    check("post_rst_rdata", 32'(rdata), 32'h99);
`endif

    // Depth-5 instance: 20-word stream across pointer wrap
    for (int i = 0; i < 5; i++) begin
      b_w_en = 1; b_wdata = 8'hC0 + i[7:0];
      tick();
    end
    check("b_fill_count", 32'(b_count), 5);
    check("b_fill_full",  32'(b_full), 1);
    rd = 0;
    for (int i = 5; i < 20; i++) begin
      b_w_en = 1; b_r_en = 1; b_wdata = 8'hC0 + i[7:0];
      exp_b = 8'hC0 + rd[7:0];
`ifdef FIFO_SYNC_FWFT_EN
      check("b_stream_rdata", 32'(b_rdata), 32'(exp_b));
`endif
      tick();
`ifndef FIFO_SYNC_FWFT_EN
      check("b_stream_rdata", 32'(b_rdata), 32'(exp_b));
`endif
      check("b_stream_count", 32'(b_count), 5);
      rd++;
    end
    b_w_en = 0;
    for (int i = 0; i < 5; i++) begin
      b_r_en = 1;
      exp_b = 8'hC0 + rd[7:0];
`ifdef FIFO_SYNC_FWFT_EN
      check("b_drain_rdata", 32'(b_rdata), 32'(exp_b));
`endif
      tick();
`ifndef FIFO_SYNC_FWFT_EN
      check("b_drain_rdata", 32'(b_rdata), 32'(exp_b));
`endif
      rd++;
    end
    b_r_en = 0;
    check("b_end_count", 32'(b_count), 0);
    check("b_end_empty", 32'(b_empty), 1);
    check("b_end_ovf",   32'(b_overflow), 0);
    check("b_end_udf",   32'(b_underflow), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_sync_flags.md
# fifo_sync_flags

Parametrised single-clock FIFO, successor to the basic synchronous FIFO. Adds arbitrary (non-power-of-two) depth, an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It sits between a producer and a consumer in the same clock domain. It is the standard rate-decoupling buffer for new datapath blocks.

## Interface
- MEMORY_WIDTH, 8, data word width in bits (≥1)
- MEMORY_DEPTH, 16, number of entries (≥2, any integer)
- ADDRESS_SIZE, 4, pointer width; must satisfy 2^ADDRESS_SIZE ≥ MEMORY_DEPTH
- AFULL_THRESH, 12, almost_full asserts when count ≥ this (1..MEMORY_DEPTH)
- AEMPTY_THRESH, 2, almost_empty asserts when count ≤ this (0..MEMORY_DEPTH-1)
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous clear of pointers and count
- clr_err  input  1  synchronous clear of overflow/underflow
- w_en  input  1  write request
- wdata  input  MEMORY_WIDTH  write data
- r_en  input  1  read request
- rdata  output  MEMORY_WIDTH  read data
- full, empty, almost_full, almost_empty  output  1 each  status flags
- count  output  ADDRESS_SIZE+1  current occupancy, 0..MEMORY_DEPTH
- overflow, underflow  output  1 each  sticky error flags

## Operation
- Write accepted (wr_ok) iff w_en && (!full || rd_ok). Read accepted (rd_ok) iff r_en && !empty.
- Pointers w_ptr/r_ptr advance by 1 on acceptance. They wrap from MEMORY_DEPTH-1 to 0, not at 2^ADDRESS_SIZE.
- count next = count + wr_ok − rd_ok. Simultaneous accepted read and write leave count unchanged.
- Flags decode the registered count: full = (count==MEMORY_DEPTH), empty = (count==0), almost_full = (count ≥ AFULL_THRESH), almost_empty = (count ≤ AEMPTY_THRESH).
- Read and write at full: both accepted. The read returns the old entry at r_ptr; w_ptr==r_ptr, and the read happens before the write.
- Read and write at empty: read rejected, write accepted.
- overflow sets on w_en && !wr_ok. underflow sets on r_en && !rd_ok. Both are sticky until clr_err or reset; set has priority over clr_err in the same cycle.
- flush takes priority over w_en and r_en in the same cycle. On the next edge pointers = 0 and count = 0. rdata, memory and error flags are unchanged, and no error is flagged that cycle.
- Memory contents are not reset.
- Reset values (rst low, asynchronous): pointers 0, count 0, rdata 0, empty 1, almost_empty 1, full 0, almost_full 0, overflow 0, underflow 0.

## Timing
- Write at edge N: count and flags update at edge N. The data is readable from cycle N+1.
- Default (registered) read: on rd_ok at edge N, rdata holds the entry from edge N. rdata holds its value when no read is accepted.
- Flag latency: 0 cycles after the count register, so flags are registered-equivalent.
- Throughput: one write and one read per cycle sustained.
- Reset deassertion mid-stream: the FIFO is empty; the first write is accepted on the first rising edge with rst high.

## Configuration
- FIFO_SYNC_FWFT_EN defined: first-word-fall-through. rdata = memory[r_ptr] combinationally whenever !empty, and it is valid in the same cycle empty deasserts. r_en with !empty pops the head and presents the next entry after that edge. rdata is don't-care while empty.
- FIFO_SYNC_FWFT_EN undefined: registered read as described under Timing, with one cycle of latency and the hold-last-value behaviour.

## Test plan
- Reset, then write 16 words 0x00..0x0F with no reads -> count reaches 16; full=1 after the 16th write; almost_full=1 after the 12th; overflow stays 0.
- While full, w_en=1 with r_en=0 -> overflow=1, count stays 16, contents unchanged. Then pulse clr_err -> overflow=0.
- While full, w_en=1 and r_en=1 with wdata=0xAA -> rdata=0x00, count stays 16. 0xAA is later read out as the 16th word after 0x01..0x0F.
- From empty, r_en=1 -> underflow=1, rdata unchanged, count 0. Then write 0x55 -> empty drops the next cycle. In FWFT mode rdata=0x55 the same cycle; otherwise rdata=0x55 one cycle after r_en.
- MEMORY_DEPTH=5, ADDRESS_SIZE=3: stream 20 words with concurrent read/write -> data order preserved across the 4->0 pointer wrap; count never exceeds 5.
- Fill to 7 entries, assert flush together with w_en and r_en -> count=0 and empty=1 the next cycle; no error flags set. Also assert rst low mid-burst -> all outputs return to their reset values immediately.
